// File: rtl/opfetch_pkg.sv
// Shared decode types, field positions and instruction-class constants for operand_fetch.
package opfetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned FS_W   = 4;
  localparam int unsigned SH_W   = 5;
  localparam int unsigned IMM_W  = 15;

  localparam int unsigned OPC_LSB = 25;
  localparam int unsigned DR_LSB  = 20;
  localparam int unsigned SA_LSB  = 15;
  localparam int unsigned SB_LSB  = 10;
  localparam int unsigned FS_LSB  = 6;
  localparam int unsigned SH_LSB  = 0;

  localparam logic [1:0] CLS_ALU_R = 2'b00;
  localparam logic [1:0] CLS_ALU_I = 2'b01;
  localparam logic [1:0] CLS_LD    = 2'b10;
  localparam logic [1:0] CLS_ST    = 2'b11;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [FS_W-1:0]   fs;
    logic [SH_W-1:0]   sh;
    logic              mw;
    logic              rw;
    logic              md;
    logic [REG_AW-1:0] dr;
    logic [REG_AW-1:0] sa;
    logic [REG_AW-1:0] sb;
    logic              use_sb;
    logic [XLEN-1:0]   imm;
  } decoded_t;

  // Field extraction plus per-class control; dr==0 never writes back.
  function automatic decoded_t decode(input logic [XLEN-1:0] inst);
    decoded_t d;
    d.opcode = inst[OPC_LSB +: OPC_W];
    d.dr     = inst[DR_LSB +: REG_AW];
    d.sa     = inst[SA_LSB +: REG_AW];
    d.sb     = inst[SB_LSB +: REG_AW];
    d.fs     = inst[FS_LSB +: FS_W];
    d.sh     = inst[SH_LSB +: SH_W];
    d.imm    = {{(XLEN-IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]};
    d.mw     = 1'b1;
    d.rw     = 1'b1;
    d.md     = 1'b0;
    d.use_sb = 1'b0;
    case (d.opcode[OPC_W-1 -: 2])
      CLS_ALU_R: d.use_sb = 1'b1;
      CLS_ALU_I: begin
        d.fs = d.opcode[FS_W-1:0];
        d.sh = '0;
      end
      CLS_LD:    d.md = 1'b1;
      default: begin
        d.rw     = 1'b0;
        d.mw     = 1'b0;
        d.use_sb = 1'b1;
      end
    endcase
    if (d.dr == '0) d.rw = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/reg_file_32x32.sv
// 32x32 register file: two combinational read ports, one synchronous write port, R0 reads zero.
module reg_file_32x32
  import opfetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [XLEN-1:0]   ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [XLEN-1:0]   rb_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0] regs [NREGS];

  // Writes during reset and to R0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage with pending-write scoreboard interlock.
// Build option: OPFETCH_BYPASS_EN forwards a same-cycle writeback into the operand read.
module operand_fetch
  import opfetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   inst,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   busA,
  output logic [XLEN-1:0]   busB,
  output logic [OPC_W-1:0]  opcode,
  output logic [FS_W-1:0]   fs,
  output logic [SH_W-1:0]   sh,
  output logic              mw,
  output logic              rw,
  output logic              md,
  output logic [REG_AW-1:0] dr
);

  decoded_t         dec;
  logic [XLEN-1:0]  rf_a, rf_b, op_a, op_b;
  logic [NREGS-1:0] pend_q, set_mask, clr_mask, src_busy, waw_busy;
  logic             wb_act, hazard, accept;

  assign dec    = decode(inst);
  assign wb_act = wb_en && (wb_addr != '0);

  reg_file_32x32 u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (dec.sa),
    .ra_data (rf_a),
    .rb_addr (dec.sb),
    .rb_data (rf_b),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  // Hazard detection and operand selection; pend_q[0] is never set.
  always_comb begin
    clr_mask = '0;
    op_a     = rf_a;
    op_b     = rf_b;
    if (wb_act) clr_mask = NREGS'(1) << wb_addr;
`ifdef OPFETCH_BYPASS_EN
    src_busy = pend_q & ~clr_mask;
    waw_busy = src_busy;
    if (wb_act && (wb_addr == dec.sa)) op_a = wb_data;
    if (wb_act && (wb_addr == dec.sb)) op_b = wb_data;
`else
    src_busy = pend_q | clr_mask;
    waw_busy = pend_q;
`endif
    hazard = src_busy[dec.sa] || (dec.use_sb && src_busy[dec.sb]) ||
             (dec.rw && waw_busy[dec.dr]);
    case (dec.opcode[OPC_W-1 -: 2])
      CLS_ALU_I: op_b = dec.imm;
      CLS_LD:    op_b = '0;
      default:   ;
    endcase
  end

  assign in_ready = !rst && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign set_mask = (accept && dec.rw) ? (NREGS'(1) << dec.dr) : '0;

  // Output stage and scoreboard; a same-register set beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      busA      <= '0;
      busB      <= '0;
      opcode    <= '0;
      fs        <= '0;
      sh        <= '0;
      mw        <= 1'b1;
      rw        <= 1'b0;
      md        <= 1'b0;
      dr        <= '0;
      pend_q    <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        busA      <= op_a;
        busB      <= op_b;
        opcode    <= dec.opcode;
        fs        <= dec.fs;
        sh        <= dec.sh;
        mw        <= dec.mw;
        rw        <= dec.rw;
        md        <= dec.md;
        dr        <= dec.dr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      pend_q <= (pend_q & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: reference model, decode table, hazard/hold/reset sequences, random traffic.
module tb_operand_fetch;

  logic        clk, rst, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [31:0] inst, wb_data, busA, busB;
  logic [4:0]  wb_addr, sh, dr;
  logic [6:0]  opcode;
  logic [3:0]  fs;
  logic        mw, rw, md;

  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .busA(busA), .busB(busB),
    .opcode(opcode), .fs(fs), .sh(sh), .mw(mw), .rw(rw), .md(md), .dr(dr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic last_ready;

  // Reference model state
  logic [31:0] mrf [32];
  bit          mpend [32];
  bit          e_valid, e_mw, e_rw, e_md;
  logic [31:0] e_a, e_b;
  logic [6:0]  e_opc;
  logic [3:0]  e_fs;
  logic [4:0]  e_sh, e_dr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit wbhit(input logic [4:0] r);
    return wb_en && (wb_addr == r) && (r != 5'd0);
  endfunction

  function automatic bit busy(input logic [4:0] r);
`ifdef OPFETCH_BYPASS_EN
    return mpend[r] && !wbhit(r);
`else
    return mpend[r] || wbhit(r);
`endif
  endfunction

  function automatic logic [31:0] rd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef OPFETCH_BYPASS_EN
    if (wbhit(r)) return wb_data;
`endif
    return mrf[r];
  endfunction

  function automatic bit model_ready();
    logic [1:0] cls;
    logic [4:0] d, a, b;
    bit uses_b, wr, haz, waw;
    cls = inst[31:30]; d = inst[24:20]; a = inst[19:15]; b = inst[14:10];
    uses_b = (cls == 2'd0) || (cls == 2'd3);
    wr = (cls != 2'd3) && (d != 5'd0);
    waw = mpend[d];
`ifdef OPFETCH_BYPASS_EN
    if (wbhit(d)) waw = 1'b0;
`endif
    haz = busy(a) || (uses_b && busy(b)) || (wr && waw);
    return !rst && !haz && (!e_valid || out_ready);
  endfunction

  task automatic model_update(input bit rdy);
    logic [1:0] cls;
    logic [4:0] d;
    bit acc;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mrf[i] = 32'd0; mpend[i] = 1'b0; end
      e_valid = 0; e_a = 0; e_b = 0; e_opc = 0; e_fs = 0; e_sh = 0;
      e_mw = 1; e_rw = 0; e_md = 0; e_dr = 0;
      return;
    end
    cls = inst[31:30]; d = inst[24:20];
    acc = in_valid && rdy;
    if (acc) begin
      e_valid = 1; e_opc = inst[31:25]; e_dr = d;
      e_a = rd(inst[19:15]); e_b = rd(inst[14:10]);
      e_fs = inst[9:6]; e_sh = inst[4:0];
      e_mw = 1; e_md = 0; e_rw = (d != 0);
      case (cls)
        2'd1: begin e_b = {{17{inst[14]}}, inst[14:0]}; e_fs = inst[28:25]; e_sh = 0; end
        2'd2: begin e_b = 0; e_md = 1; end
        2'd3: begin e_rw = 0; e_mw = 0; end
        default: ;
      endcase
    end else if (out_ready) begin
      e_valid = 0;
    end
    if (wb_en && wb_addr != 0) begin mpend[wb_addr] = 0; mrf[wb_addr] = wb_data; end
    if (acc && e_rw) mpend[d] = 1;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("busA", busA, e_a);
    chk("busB", busB, e_b);
    chk("opcode", 32'(opcode), 32'(e_opc));
    chk("fs", 32'(fs), 32'(e_fs));
    chk("sh", 32'(sh), 32'(e_sh));
    chk("mw", 32'(mw), 32'(e_mw));
    chk("rw", 32'(rw), 32'(e_rw));
    chk("md", 32'(md), 32'(e_md));
    chk("dr", 32'(dr), 32'(e_dr));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    bit exp_rdy;
    #1;
    exp_rdy = model_ready();
    last_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    model_update(exp_rdy);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] mk_r(input logic [6:0] o, input logic [4:0] d, input logic [4:0] a,
                                       input logic [4:0] b, input logic [3:0] f, input logic [4:0] s);
    return {o, d, a, b, f, 1'b0, s};
  endfunction

  function automatic logic [31:0] mk_i(input logic [6:0] o, input logic [4:0] d, input logic [4:0] a,
                                       input logic [14:0] imm);
    return {o, d, a, imm};
  endfunction

  task automatic wb_write(input logic [4:0] a, input logic [31:0] v);
    wb_en = 1; wb_addr = a; wb_data = v;
    tick();
    wb_en = 0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] a, b;
    logic [3:0]  fs;
    logic [4:0]  sh;
    logic        mw, rw, md;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{mk_r(7'h05, 5'd10, 5'd3, 5'd0, 4'h9, 5'd7), 32'h12345678, 32'h0, 4'h9, 5'd7, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{mk_i(7'h2A, 5'd11, 5'd1, 15'h7FFF), 32'h11111111, 32'hFFFFFFFF, 4'hA, 5'd0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{mk_i(7'h23, 5'd12, 5'd2, 15'h1234), 32'h22222222, 32'h00001234, 4'h3, 5'd0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{mk_r(7'h41, 5'd13, 5'd4, 5'd1, 4'h5, 5'd3), 32'hCAFEF00D, 32'h0, 4'h5, 5'd3, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{mk_r(7'h60, 5'd14, 5'd2, 5'd4, 4'h1, 5'd2), 32'h22222222, 32'hCAFEF00D, 4'h1, 5'd2, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{mk_r(7'h00, 5'd0, 5'd1, 5'd2, 4'h0, 5'd0), 32'h11111111, 32'h22222222, 4'h0, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{mk_r(7'h1F, 5'd15, 5'd2, 5'd1, 4'hF, 5'd31), 32'h22222222, 32'h11111111, 4'hF, 5'd31, 1'b1, 1'b1, 1'b0};

    rst = 1; in_valid = 0; inst = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    @(negedge clk);
    tick();
    chk("rst_in_ready", 32'(last_ready), 32'd0);
    chk("rst_mw", 32'(mw), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 0;

    wb_write(5'd1, 32'h11111111);
    wb_write(5'd2, 32'h22222222);
    wb_write(5'd3, 32'h12345678);
    wb_write(5'd4, 32'hCAFEF00D);

    // Decode table, issued back-to-back
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; inst = tbl[i].inst;
      tick();
      chk($sformatf("tbl%0d_ready", i), 32'(last_ready), 32'd1);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_busA", i), busA, tbl[i].a);
      chk($sformatf("tbl%0d_busB", i), busB, tbl[i].b);
      chk($sformatf("tbl%0d_fs", i), 32'(fs), 32'(tbl[i].fs));
      chk($sformatf("tbl%0d_sh", i), 32'(sh), 32'(tbl[i].sh));
      chk($sformatf("tbl%0d_ctl", i), 32'({mw, rw, md}), 32'({tbl[i].mw, tbl[i].rw, tbl[i].md}));
    end
    in_valid = 0;
    for (int r = 10; r < 16; r++) wb_write(5'(r), 32'd0);

    // Load-use interlock
    in_valid = 1; inst = mk_r(7'h40, 5'd5, 5'd0, 5'd0, 4'h0, 5'd0);
    tick();
    inst = mk_r(7'h00, 5'd6, 5'd5, 5'd0, 4'h2, 5'd0);
    tick();
    chk("lu_stall0", 32'(last_ready), 32'd0);
    tick();
    chk("lu_stall1", 32'(last_ready), 32'd0);
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'hA5;
    tick();
    wb_en = 0;
`ifdef OPFETCH_BYPASS_EN
    chk("lu_wb_cycle_ready", 32'(last_ready), 32'd1);
`else
    chk("lu_wb_cycle_ready", 32'(last_ready), 32'd0);
    tick();
    chk("lu_next_ready", 32'(last_ready), 32'd1);
`endif
    chk("lu_valid", 32'(out_valid), 32'd1);
    chk("lu_busA", busA, 32'hA5);
    in_valid = 0;
    wb_write(5'd6, 32'h66);

    // Output hold under back-pressure
    in_valid = 1; inst = mk_r(7'h00, 5'd0, 5'd1, 5'd2, 4'h0, 5'd0);
    tick();
    out_ready = 0; inst = mk_r(7'h00, 5'd0, 5'd3, 5'd4, 4'h0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_ready", 32'(last_ready), 32'd0);
      chk("hold_busA", busA, 32'h11111111);
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1;
    tick();
    chk("release_ready", 32'(last_ready), 32'd1);
    chk("release_busA", busA, 32'h12345678);
    chk("release_busB", busB, 32'hCAFEF00D);
    in_valid = 0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // dr==0 and writes to R0
    in_valid = 1; inst = mk_r(7'h00, 5'd0, 5'd0, 5'd0, 4'h0, 5'd0);
    wb_en = 1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 0;
    chk("r0_rw", 32'(rw), 32'd0);
    tick();
    chk("r0_ready", 32'(last_ready), 32'd1);
    chk("r0_busA", busA, 32'd0);
    chk("r0_busB", busB, 32'd0);

    // Store sets no pending bit
    inst = mk_r(7'h60, 5'd9, 5'd2, 5'd4, 4'h0, 5'd0);
    tick();
    chk("st_mw", 32'(mw), 32'd0);
    chk("st_busB", busB, 32'hCAFEF00D);
    inst = mk_r(7'h00, 5'd0, 5'd9, 5'd0, 4'h0, 5'd0);
    tick();
    chk("st_nopend_ready", 32'(last_ready), 32'd1);

    // Reset mid-operation
    inst = mk_r(7'h40, 5'd7, 5'd1, 5'd0, 4'h0, 5'd0);
    tick();
    out_ready = 0; in_valid = 0;
    tick();
    rst = 1; wb_en = 1; wb_addr = 5'd3; wb_data = 32'hFFFF;
    tick();
    chk("midrst_ready", 32'(last_ready), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    rst = 0; wb_en = 0; out_ready = 1;
    in_valid = 1; inst = mk_r(7'h00, 5'd8, 5'd7, 5'd3, 4'h0, 5'd0);
    tick();
    chk("postrst_ready", 32'(last_ready), 32'd1);
    chk("postrst_busB", busB, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      inst      = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 10'($urandom)};
      wb_en     = $urandom_range(0, 1) != 0;
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch stage feeding the execute stage. Accepts one 32-bit instruction per handshake, decodes it, reads a 32×32 register file (R0 reads zero), and presents registered `busA`/`busB`/`opcode`/`fs`/`sh` plus control to execute. A pending-write scoreboard interlocks RAW/WAW hazards against results returning on the writeback port.

## Interface
- `RESET_PC_UNUSED`: no parameters. Widths are fixed by the instruction format.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `in_valid  in  1`: instruction valid.
- `in_ready  out  1`: stage can accept this cycle.
- `inst  in  32`: instruction word.
- `wb_en  in  1`: writeback strobe.
- `wb_addr  in  5`: writeback register.
- `wb_data  in  32`: writeback value.
- `out_valid  out  1`: execute operands valid.
- `out_ready  in  1`: execute accepts.
- `busA`, `busB  out  32`: operands.
- `opcode  out  7`, `fs  out  4`, `sh  out  5`: function-unit controls.
- `mw  out  1`: data-memory write enable, active-low; 0 means store.
- `rw  out  1`: register write.
- `md  out  1`: result from memory.
- `dr  out  5`: destination register.

## Operation
- Fields: `opcode=inst[31:25]`, `dr=inst[24:20]`, `sa=inst[19:15]`, `sb=inst[14:10]`, `fs=inst[9:6]`, `sh=inst[4:0]`.
- Class is `opcode[6:5]`:
  - 00 ALU-reg: `busA=R[sa]`, `busB=R[sb]`, `rw=1`, `md=0`, `mw=1`.
  - 01 ALU-imm: `busB` = sign-extended `inst[14:0]`, `fs=opcode[3:0]`, `sh=0`, `rw=1`.
  - 10 load: `busA=R[sa]` as address, `busB=0`, `rw=1`, `md=1`, `mw=1`.
  - 11 store: `busA=R[sa]` as address, `busB=R[sb]` as data, `rw=0`, `mw=0`.
- If `dr==0`, force `rw=0`. Writes to R0 are ignored. R0 always reads 0.
- Register file: the write port is `wb_en`/`wb_addr`/`wb_data`, committed at the clock edge.
- Scoreboard `pend[31:1]`:
  - Set `pend[dr]` when an instruction with `rw=1` is accepted.
  - Clear `pend[wb_addr]` on `wb_en`.
  - If set and clear hit the same register in the same cycle, set wins.
- Sources used: `sa` for all classes, and `sb` for classes 00 and 11.
- Hazard is true if any used source is pending, or if `rw=1` and `pend[dr]` is set (WAW). The bypass qualification is under Configuration.
- `in_ready = !hazard && (!out_valid || out_ready)`.

## Timing
- Accept happens on a cycle with `in_valid && in_ready`. Operands are read combinationally that cycle. Output registers load at the edge, so `out_valid` rises the next cycle. Latency is 1 cycle.
- The output holds stable while `out_valid && !out_ready`.
- `out_valid` clears after `out_ready` unless a new instruction is accepted in the same cycle (back-to-back throughput of 1 per cycle).
- Reset values: `out_valid=0`, `busA=busB=0`, `opcode=0`, `fs=0`, `sh=0`, `mw=1`, `rw=0`, `md=0`, `dr=0`, `pend=0`, all registers 0.
- `in_ready` is 0 during the reset cycle.
- Reset mid-operation discards the held instruction and all pending bits. A `wb_en` arriving in the reset cycle is ignored.

## Configuration
- `OPFETCH_BYPASS_EN` defined:
  - A source equal to `wb_addr` while `wb_en` (nonzero) takes `wb_data`.
  - The pending bit being cleared that cycle does not cause a hazard.
  - A dependent instruction issues in the same cycle as its writeback.
- Not defined:
  - Any source matching an active `wb_addr` is treated as a hazard.
  - The instruction issues on the following cycle and reads the committed value.
  - There is one extra stall cycle per dependence.

## Structure
- Package `opfetch_pkg` holds:
  - class constants `CLS_ALU_R`, `CLS_ALU_I`, `CLS_LD`, `CLS_ST`;
  - field bit-position constants;
  - a typedef `decoded_t` bundling `opcode`, `fs`, `sh`, `mw`, `rw`, `md`, `dr`, `sa`, `sb`, `use_sb`, `imm`.
- Sub-module `reg_file_32x32`: 2 combinational read ports, 1 synchronous write port, R0 hardwired to zero. Bypass and scoreboard stay in `operand_fetch`.

## Test plan
- Reset, then write R3=0x12345678 via wb, then issue ALU-reg sa=3, sb=0 → next cycle `out_valid=1`, `busA=0x12345678`, `busB=0`.
- ALU-imm with `inst[14:0]=0x7FFF` → `busB=0xFFFFFFFF`, `fs=opcode[3:0]`, `sh=0`.
- Load dr=5, then ALU sa=5 → `in_ready=0` until `wb_en` with addr 5 and data 0xA5. With bypass: issues that cycle with `busA=0xA5`. Without bypass: issues one cycle later with the same value.
- Store with sa=2, sb=4 → `mw=0`, `rw=0`, `busB=R4`, and no pending bit set.
- Hold `out_ready=0` for 3 cycles with `in_valid=1` → outputs stable, `in_ready=0`, no instruction lost or duplicated.
- Instruction with dr=0 → `rw=0`, `pend` unchanged, and a later read of R0 returns 0 even after `wb_en` to address 0.
